writeburst_arbiter: RTL and testbench

WRITEBURST_ARBITER -- requirements
Module: writeburst_arbiter

---
 rtl/writeburst_arbiter_pkg.sv | 27 ++
 rtl/writeburst_arbiter.sv | 113 +++++++++++
 tb/tb_writeburst_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/writeburst_arbiter_pkg.sv
// Shared defines for the two-requester write-burst arbiter: FSM encodings,
// payload widths, the captured burst record and the two-way pick rule.
package writeburst_arbiter_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_LEN_W  = 2;
  localparam int WB_BE_W   = 4;
  localparam int WB_DATA_W = 56;

  localparam logic [1:0] WB_ARB_IDLE = 2'd0;
  localparam logic [1:0] WB_ARB_BUSY = 2'd1;
  localparam logic [1:0] WB_ARB_DONE = 2'd2;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] address;
    logic [WB_LEN_W-1:0]  dword_length;
    logic [WB_BE_W-1:0]   byteenable_0;
    logic [WB_BE_W-1:0]   byteenable_1;
    logic [WB_DATA_W-1:0] data;
  } wb_burst_t;

  // A lone requester always wins; a tie goes to the preferred index.
  function automatic logic wb_pick(input logic do0, input logic do1, input logic pref);
    return (do0 && do1) ? pref : do1;
  endfunction

endpackage

// File: rtl/writeburst_arbiter.sv
// Two-way write-burst arbiter onto one shared write port. Round-robin by
// default; defining WRITEBURST_ARB_FIXED_PRIO_EN makes requester 0 win all ties.
module writeburst_arbiter
  import writeburst_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 req0_writeburst_do,
  output logic                 req0_writeburst_done,
  input  logic [WB_ADDR_W-1:0] req0_writeburst_address,
  input  logic [WB_LEN_W-1:0]  req0_writeburst_dword_length,
  input  logic [WB_BE_W-1:0]   req0_writeburst_byteenable_0,
  input  logic [WB_BE_W-1:0]   req0_writeburst_byteenable_1,
  input  logic [WB_DATA_W-1:0] req0_writeburst_data,

  input  logic                 req1_writeburst_do,
  output logic                 req1_writeburst_done,
  input  logic [WB_ADDR_W-1:0] req1_writeburst_address,
  input  logic [WB_LEN_W-1:0]  req1_writeburst_dword_length,
  input  logic [WB_BE_W-1:0]   req1_writeburst_byteenable_0,
  input  logic [WB_BE_W-1:0]   req1_writeburst_byteenable_1,
  input  logic [WB_DATA_W-1:0] req1_writeburst_data,

  output logic                 resp_writeburst_do,
  input  logic                 resp_writeburst_done,
  output logic [WB_ADDR_W-1:0] resp_writeburst_address,
  output logic [WB_LEN_W-1:0]  resp_writeburst_dword_length,
  output logic [WB_BE_W-1:0]   resp_writeburst_byteenable_0,
  output logic [WB_BE_W-1:0]   resp_writeburst_byteenable_1,
  output logic [WB_DATA_W-1:0] resp_writeburst_data,

  output logic                 grant_owner
);

  logic [1:0] state_q;
  logic       owner_q;
  wb_burst_t  cap_q;
  wb_burst_t  req0_burst;
  wb_burst_t  req1_burst;
  logic       pick;
  logic       pref;

  assign req0_burst = '{address:      req0_writeburst_address,
                        dword_length: req0_writeburst_dword_length,
                        byteenable_0: req0_writeburst_byteenable_0,
                        byteenable_1: req0_writeburst_byteenable_1,
                        data:         req0_writeburst_data};
  assign req1_burst = '{address:      req1_writeburst_address,
                        dword_length: req1_writeburst_dword_length,
                        byteenable_0: req1_writeburst_byteenable_0,
                        byteenable_1: req1_writeburst_byteenable_1,
                        data:         req1_writeburst_data};

`ifdef WRITEBURST_ARB_FIXED_PRIO_EN
  assign pref = 1'b0;
`else
  logic ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (state_q == WB_ARB_IDLE && (req0_writeburst_do || req1_writeburst_do)) begin
      ptr_q <= ~pick;
    end
  end

  assign pref = ptr_q;
`endif

  assign pick = wb_pick(req0_writeburst_do, req1_writeburst_do, pref);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WB_ARB_IDLE;
      owner_q <= 1'b0;
      // NOTE: the capture register is reset so the shared port never sees
      // stale payload from before reset.
      cap_q   <= '0;
    end else begin
      unique case (state_q)
        WB_ARB_IDLE: begin
          if (req0_writeburst_do || req1_writeburst_do) begin
            state_q <= WB_ARB_BUSY;
            owner_q <= pick;
            cap_q   <= pick ? req1_burst : req0_burst;
          end
        end
        WB_ARB_BUSY: begin
          if (resp_writeburst_done) state_q <= WB_ARB_DONE;
        end
        // The finisher still holds do here, so no arbitration this cycle.
        WB_ARB_DONE: state_q <= WB_ARB_IDLE;
        default:     state_q <= WB_ARB_IDLE;
      endcase
    end
  end

  // All handshake outputs decode registered state only.
  assign resp_writeburst_do   = (state_q == WB_ARB_BUSY);
  assign req0_writeburst_done = (state_q == WB_ARB_DONE) && !owner_q;
  assign req1_writeburst_done = (state_q == WB_ARB_DONE) &&  owner_q;
  assign grant_owner          = owner_q;

  assign resp_writeburst_address      = cap_q.address;
  assign resp_writeburst_dword_length = cap_q.dword_length;
  assign resp_writeburst_byteenable_0 = cap_q.byteenable_0;
  assign resp_writeburst_byteenable_1 = cap_q.byteenable_1;
  assign resp_writeburst_data         = cap_q.data;

endmodule

// File: tb/tb_writeburst_arbiter.sv
// Self-checking bench for writeburst_arbiter: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a burst-level model.
module tb_writeburst_arbiter;
  import writeburst_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic do0, do1, resp_done;
  wb_burst_t p0, p1;

  logic req0_done, req1_done, resp_do, grant_owner;
  logic [WB_ADDR_W-1:0] resp_address;
  logic [WB_LEN_W-1:0]  resp_len;
  logic [WB_BE_W-1:0]   resp_be0, resp_be1;
  logic [WB_DATA_W-1:0] resp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeburst_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_writeburst_do(do0), .req0_writeburst_done(req0_done),
    .req0_writeburst_address(p0.address), .req0_writeburst_dword_length(p0.dword_length),
    .req0_writeburst_byteenable_0(p0.byteenable_0), .req0_writeburst_byteenable_1(p0.byteenable_1),
    .req0_writeburst_data(p0.data),
    .req1_writeburst_do(do1), .req1_writeburst_done(req1_done),
    .req1_writeburst_address(p1.address), .req1_writeburst_dword_length(p1.dword_length),
    .req1_writeburst_byteenable_0(p1.byteenable_0), .req1_writeburst_byteenable_1(p1.byteenable_1),
    .req1_writeburst_data(p1.data),
    .resp_writeburst_do(resp_do), .resp_writeburst_done(resp_done),
    .resp_writeburst_address(resp_address), .resp_writeburst_dword_length(resp_len),
    .resp_writeburst_byteenable_0(resp_be0), .resp_writeburst_byteenable_1(resp_be1),
    .resp_writeburst_data(resp_data),
    .grant_owner(grant_owner)
  );

  // Burst-level model: a grant is outstanding, a completion beat is due, or neither.
  logic      m_granted, m_completing, m_owner, m_pref;
  wb_burst_t m_burst;

  function automatic logic winner(input logic a, input logic b, input logic pref);
`ifdef WRITEBURST_ARB_FIXED_PRIO_EN
    return !a;
`else
    if (a && b) return pref;
    return b;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_granted <= 1'b0; m_completing <= 1'b0; m_owner <= 1'b0; m_pref <= 1'b0; m_burst <= '0;
    end else if (m_completing) begin
      m_completing <= 1'b0;
    end else if (m_granted) begin
      if (resp_done) begin
        m_granted <= 1'b0; m_completing <= 1'b1;
      end
    end else if (do0 || do1) begin
      m_owner   <= winner(do0, do1, m_pref);
      m_burst   <= winner(do0, do1, m_pref) ? p1 : p0;
      m_pref    <= !winner(do0, do1, m_pref);
      m_granted <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wb_burst_t resp_burst();
    return '{address: resp_address, dword_length: resp_len, byteenable_0: resp_be0,
             byteenable_1: resp_be1, data: resp_data};
  endfunction

  function automatic wb_burst_t rand_burst();
    logic [63:0] d;
    wb_burst_t b;
    d = {$urandom(), $urandom()};
    b.address      = $urandom();
    b.dword_length = 2'($urandom_range(1, 2));
    b.byteenable_0 = 4'($urandom());
    b.byteenable_1 = 4'($urandom());
    b.data         = d[55:0];
    return b;
  endfunction

  // Advance one cycle, then compare the DUT with the model away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    check("resp_do", resp_do, m_granted);
    check("req0_done", req0_done, m_completing && !m_owner);
    check("req1_done", req1_done, m_completing && m_owner);
    check("grant_owner", grant_owner, m_owner);
    if (m_granted) check("payload", resp_burst(), m_burst);
  endtask

  task automatic do_reset();
    rst = 1'b1; do0 = 1'b0; do1 = 1'b0; resp_done = 1'b0; p0 = '0; p1 = '0;
    tick(); tick();
  endtask

  int gcyc[$];
  logic gown[$];

  initial begin
    // Reset state.
    do_reset();
    check("rst_resp_do", resp_do, 1'b0);
    check("rst_owner", grant_owner, 1'b0);
    check("rst_done0", req0_done, 1'b0);
    check("rst_address", resp_address, 32'h0);

    // Single request with a payload change mid-burst.
    rst = 1'b0; do0 = 1'b1;
    p0 = '{address: 32'h0000_1000, dword_length: 2'd2, byteenable_0: 4'hF,
           byteenable_1: 4'h3, data: 56'h11223344556677};
    tick();                                        // cycle 1
    check("c1_resp_do", resp_do, 1'b1);
    check("c1_address", resp_address, 32'h0000_1000);
    check("c1_length", resp_len, 2'd2);
    check("c1_data", resp_data, 56'h11223344556677);
    p0.address = 32'hDEAD_BEE0;
    tick();                                        // cycle 2
    check("c2_address_held", resp_address, 32'h0000_1000);
    check("c2_done1", req1_done, 1'b0);
    tick(); tick();                                // cycle 4
    check("c4_done0", req0_done, 1'b0);
    resp_done = 1'b1;
    tick();                                        // cycle 5
    check("c5_done0", req0_done, 1'b1);
    check("c5_resp_do", resp_do, 1'b0);
    check("c5_done1", req1_done, 1'b0);
    resp_done = 1'b0; do0 = 1'b0;
    tick();                                        // cycle 6
    check("c6_done0", req0_done, 1'b0);
    check("c6_resp_do", resp_do, 1'b0);

    // Both requesting continuously, downstream completes at once.
    do_reset();
    rst = 1'b0; do0 = 1'b1; do1 = 1'b1; p0 = rand_burst(); p1 = rand_burst();
    for (int k = 1; k <= 40 && gcyc.size() < 3; k++) begin
      logic was_do;
      was_do = resp_do;
      tick();
      if (resp_do && !was_do) begin
        gcyc.push_back(k); gown.push_back(grant_owner);
      end
      resp_done = resp_do;
    end
    check("rr_grant_count", gcyc.size(), 3);
    if (gcyc.size() == 3) begin
      check("grant1_cycle", gcyc[0], 1);
      check("grant2_cycle", gcyc[1], 4);
      check("grant3_cycle", gcyc[2], 7);
      check("grant1_owner", gown[0], 1'b0);
`ifdef WRITEBURST_ARB_FIXED_PRIO_EN
      check("grant2_owner", gown[1], 1'b0);
`else
      check("grant2_owner", gown[1], 1'b1);
`endif
      check("grant3_owner", gown[2], 1'b0);
    end

    // Reset mid-burst, then a spurious completion while idle.
    do_reset();
    rst = 1'b0; do0 = 1'b1; p0 = rand_burst();
    tick(); tick();
    check("mid_busy", resp_do, 1'b1);
    rst = 1'b1;
    tick();
    check("mid_rst_do", resp_do, 1'b0);
    check("mid_rst_done0", req0_done, 1'b0);
    rst = 1'b0; do0 = 1'b0; resp_done = 1'b1;
    tick();
    check("spur_do", resp_do, 1'b0);
    resp_done = 1'b0;
    tick();
    check("spur_do2", resp_do, 1'b0);
    check("spur_done0", req0_done, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (do0 && req0_done) do0 = 1'b0;
      else if (!do0 && ($urandom() % 2 == 0)) begin do0 = 1'b1; p0 = rand_burst(); end
      else if (do0 && resp_do && !grant_owner && ($urandom() % 4 == 0)) p0.address = $urandom();
      if (do1 && req1_done) do1 = 1'b0;
      else if (!do1 && ($urandom() % 2 == 0)) begin do1 = 1'b1; p1 = rand_burst(); end
      else if (do1 && resp_do && grant_owner && ($urandom() % 4 == 0)) p1.address = $urandom();
      resp_done = ($urandom() % 3 == 0);
      rst = ($urandom() % 150 == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
